// File: rtl/mem_scan_disp.sv
// Step-triggered RAM reader: captures the sequencer address, fetches one 16-bit
// word and shows it on a 4-digit multiplexed hex display; the address drives the LEDs.
module mem_scan_disp #(
    parameter int unsigned REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr,
    input  logic        step,
    input  logic [15:0] mem_dout,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic [7:0]  led,
    output logic [3:0]  anode,
    output logic [6:0]  cathode
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e                  state_q;
    logic [AW-1:0]           mem_addr_q;
    logic [AW-1:0]           led_q;
    logic [DW-1:0]           data_q;
    logic [REFRESH_BITS-1:0] refresh_q;

    logic [1:0]              sel;
    logic [NW-1:0]           nibble;

    // Read transaction sequencing and free-running display refresh counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            led_q      <= '0;
            data_q     <= '0;
            refresh_q  <= '0;
        end else begin
            refresh_q <= refresh_q + REFRESH_BITS'(1);
            case (state_q)
                IDLE: begin
                    if (step) begin
                        mem_addr_q <= addr;
                        led_q      <= addr;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    data_q  <= mem_dout;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd   = (state_q == READ);
    assign busy     = (state_q != IDLE);
    assign mem_addr = mem_addr_q;
    assign led      = led_q;

    // Top two refresh bits pick the digit; each digit lit for a quarter period.
    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        anode  = 4'b1111;
        nibble = '0;
        case (sel)
            2'd0: begin anode = 4'b1110; nibble = data_q[3:0];   end
            2'd1: begin anode = 4'b1101; nibble = data_q[7:4];   end
            2'd2: begin anode = 4'b1011; nibble = data_q[11:8];  end
            2'd3: begin anode = 4'b0111; nibble = data_q[15:12]; end
            default: begin anode = 4'b1111; nibble = '0;          end
        endcase
    end

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        cathode = 7'b1111111;
        case (nibble)
            4'h0: cathode = 7'b1000000;
            4'h1: cathode = 7'b1111001;
            4'h2: cathode = 7'b0100100;
            4'h3: cathode = 7'b0110000;
            4'h4: cathode = 7'b0011001;
            4'h5: cathode = 7'b0010010;
            4'h6: cathode = 7'b0000010;
            4'h7: cathode = 7'b1111000;
            4'h8: cathode = 7'b0000000;
            4'h9: cathode = 7'b0010000;
            4'hA: cathode = 7'b0001000;
            4'hB: cathode = 7'b0000011;
            4'hC: cathode = 7'b1000110;
            4'hD: cathode = 7'b0100001;
            4'hE: cathode = 7'b0000110;
            4'hF: cathode = 7'b0001110;
            default: cathode = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_mem_scan_disp.sv
// Self-checking bench for mem_scan_disp: time-based reference model plus directed
// literal checks, with a synchronous RAM model behind the read port.
module tb_mem_scan_disp;

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic        step;
    logic [15:0] mem_dout;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        busy;
    logic [7:0]  led;
    logic [3:0]  anode;
    logic [6:0]  cathode;

    mem_scan_disp #(.REFRESH_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .step     (step),
        .mem_dout (mem_dout),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .busy     (busy),
        .led      (led),
        .anode    (anode),
        .cathode  (cathode)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [256];
    logic [6:0]  seg_m [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [3:0]  an_lit [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  a5f1_lit [4] = '{7'b1111001, 7'b0001110, 7'b0010010, 7'b0001000};
    logic [6:0]  n1234_lit [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: registers the word on the edge after the read strobe.
    initial mem_dout = 16'h0000;
    always @(posedge clk) if (mem_rd) mem_dout <= ram[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: k = edges since reset, acc = edge at which a step was taken.
    int          k;
    int          acc;
    bit          has_txn;
    logic [7:0]  cap;
    logic [15:0] data_m;
    bit          busy_before;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k = 0; acc = 0; has_txn = 0; cap = 8'h00; data_m = 16'h0000;
        end else begin
            busy_before = has_txn && (k - acc) < 2;
            k++;
            if (!busy_before && step) begin
                has_txn = 1; acc = k; cap = addr;
            end
            if (has_txn && (k - acc) == 2) data_m = ram[cap];
        end
    end

    int dig;
    always @(negedge clk) begin
        dig = (k % 16) / 4;
        chk("mem_rd",   32'(mem_rd),   32'(has_txn && k == acc));
        chk("busy",     32'(busy),     32'(has_txn && (k - acc) < 2));
        chk("mem_addr", 32'(mem_addr), 32'(cap));
        chk("led",      32'(led),      32'(cap));
        chk("anode",    32'(anode),    32'(4'b1111 ^ (4'b0001 << dig)));
        chk("cathode",  32'(cathode),  32'(seg_m[(data_m >> (4 * dig)) & 16'h000F]));
    end

    int         rd_cnt;
    int         busy_cnt;
    logic [7:0] rd_addr;
    always @(negedge clk) begin
        if (mem_rd) begin rd_cnt++; rd_addr = mem_addr; end
        if (busy) busy_cnt++;
    end

    task automatic cyc(input logic s, input logic [7:0] a);
        @(posedge clk);
        #2;
        step = s;
        addr = a;
    endtask

    // Align to the first cycle of digit 0 (after seeing digit 3), bounded.
    task automatic sync_digit0();
        bit ok;
        bit seen3;
        ok = 0;
        seen3 = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (anode == 4'b0111) seen3 = 1;
            else if (seen3 && anode == 4'b1110) begin ok = 1; break; end
        end
        chk("sync_digit0_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
        reset = 1'b0;
        step  = 1'b0;
        addr  = 8'h00;

        // Reset held with step toggling.
        for (int i = 0; i < 8; i++) cyc(i[0], 8'($urandom));
        @(negedge clk);
        chk("rst_anode",   32'(anode),   32'(4'b1110));
        chk("rst_cathode", 32'(cathode), 32'(7'b1000000));
        chk("rst_led",     32'(led),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step  = 1'b0;

        // Single read of 3C.
        ram[8'h3C] = 16'hA5F1;
        cyc(0, 8'h00);
        rd_cnt = 0; busy_cnt = 0;
        cyc(1, 8'h3C);
        for (int i = 0; i < 5; i++) cyc(0, 8'($urandom));
        chk("single_rd_pulses", 32'(rd_cnt),   32'd1);
        chk("single_busy_cyc",  32'(busy_cnt), 32'd2);
        chk("single_rd_addr",   32'(rd_addr),  32'h3C);
        chk("single_led",       32'(led),      32'h3C);
        sync_digit0();
        for (int j = 0; j < 16; j++) begin
            chk("a5f1_anode",   32'(anode),   32'(an_lit[j / 4]));
            chk("a5f1_cathode", 32'(cathode), 32'(a5f1_lit[j / 4]));
            @(negedge clk);
        end

        // Busy rejection: steps on E0..E2 give one read; E0..E3 give two.
        cyc(0, 8'h00);
        rd_cnt = 0;
        cyc(1, 8'h20); cyc(1, 8'h21); cyc(1, 8'h22);
        for (int i = 0; i < 4; i++) cyc(0, 8'($urandom));
        chk("reject_pulses", 32'(rd_cnt), 32'd1);
        chk("reject_led",    32'(led),    32'h20);
        rd_cnt = 0;
        cyc(1, 8'h30); cyc(1, 8'h31); cyc(1, 8'h32); cyc(1, 8'h33);
        for (int i = 0; i < 4; i++) cyc(0, 8'($urandom));
        chk("e3_pulses", 32'(rd_cnt), 32'd2);
        chk("e3_led",    32'(led),    32'h33);

        // Address FF with zero data.
        ram[8'hFF] = 16'h0000;
        cyc(1, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(0, 8'($urandom));
        chk("wrap_mem_addr", 32'(mem_addr), 32'hFF);
        sync_digit0();
        for (int j = 0; j < 16; j++) begin
            chk("wrap_cathode", 32'(cathode), 32'(7'b1000000));
            @(negedge clk);
        end

        // Refresh sweep with 1234.
        ram[8'h47] = 16'h1234;
        cyc(1, 8'h47);
        for (int i = 0; i < 3; i++) cyc(0, 8'($urandom));
        sync_digit0();
        for (int j = 0; j < 32; j++) begin
            chk("sweep_anode",   32'(anode),   32'(an_lit[(j % 16) / 4]));
            chk("sweep_cathode", 32'(cathode), 32'(n1234_lit[(j % 16) / 4]));
            @(negedge clk);
        end

        // Abort during LATCH.
        ram[8'h5A] = 16'hBEEF;
        cyc(1, 8'h5A);
        cyc(0, 8'h11);
        @(posedge clk);
        #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy",  32'(busy),   32'd0);
        chk("abort_led",   32'(led),    32'd0);
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("abort_cathode", 32'(cathode), 32'(7'b1000000));
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                @(posedge clk);
                #2;
                reset = 1'b0;
                @(posedge clk);
                #2;
                reset = 1'b1;
            end else begin
                cyc(($urandom_range(0, 2) == 0), 8'($urandom));
            end
        end
        cyc(0, 8'h00);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
